// File: rtl/vram_console_pkg.sv
// Shared definitions for the text-console VRAM writer: op-codes, FSM encoding
// and the screen geometry defaults also used by the display path.
package vram_console_pkg;

    localparam int COLS_DEF = 40;
    localparam int ROWS_DEF = 30;
    localparam int AW_DEF   = 11;

    localparam logic [1:0] OP_PUTC    = 2'd0;
    localparam logic [1:0] OP_SETPOS  = 2'd1;
    localparam logic [1:0] OP_NEWLINE = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETPOS = 2'd2
    } state_t;

endpackage

// File: rtl/vram_console_cursor_tracker.sv
// Hardware cursor: linear address kept in step with col/row counters.
// A loaded address is split into col/row by repeated subtraction over several cycles.
module cursor_tracker
    import vram_console_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          newline,
    input  logic          load,
    input  logic          zero,
    input  logic [AW-1:0] load_addr,
    output logic [AW-1:0] addr,
    output logic          settling
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] rem;
    logic          last_col;
    logic          last_row;

    assign last_col = (col == CW'(COLS - 1));
    assign last_row = (row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (reset || zero) begin
            addr     <= '0;
            col      <= '0;
            row      <= '0;
            rem      <= '0;
            settling <= 1'b0;
        end else if (load) begin
            addr     <= load_addr;
            col      <= '0;
            row      <= '0;
            rem      <= load_addr;
            settling <= 1'b1;
        end else if (settling) begin
            // One row peeled off per cycle; the remainder becomes the column.
            if (rem >= AW'(COLS)) begin
                rem <= rem - AW'(COLS);
                row <= row + 1'b1;
            end else begin
                col      <= CW'(rem);
                settling <= 1'b0;
            end
        end else if (newline) begin
            col <= '0;
            if (last_row) begin
                row  <= '0;
                addr <= '0;
            end else begin
                row  <= row + 1'b1;
                addr <= addr - AW'(col) + AW'(COLS);
            end
        end else if (advance) begin
            if (!last_col) begin
                col  <= col + 1'b1;
                addr <= addr + 1'b1;
            end else if (!last_row) begin
                col  <= '0;
                row  <= row + 1'b1;
                addr <= addr + 1'b1;
            end else begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end
        end
    end

endmodule

// File: rtl/vram_console.sv
// Text-console write controller: turns PUTC/SETPOS/NEWLINE/CLEAR commands into
// VRAM writes, with a valid/ready handshake held off while clearing or settling.
module vram_console
    import vram_console_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_data,
    output logic [AW-1:0] vram_waddr,
    output logic [7:0]    vram_wdata,
    output logic          vram_we,
    output logic [AW-1:0] cursor,
    output logic          busy
);

    localparam int            CELLS     = COLS * ROWS;
    localparam logic [AW:0]   CELL_LIM  = (AW + 1)'(CELLS);
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

    state_t        state, state_next;
    logic          accept;
    logic          adv, nl, ld, zero;
    logic          settling;
    logic          we_next, busy_next;
    logic [AW-1:0] waddr_next;
    logic [7:0]    wdata_next;

    assign cmd_ready = (state == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    cursor_tracker #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .advance   (adv),
        .newline   (nl),
        .load      (ld),
        .zero      (zero),
        .load_addr (cmd_data),
        .addr      (cursor),
        .settling  (settling)
    );

    always_comb begin
        state_next = state;
        adv        = 1'b0;
        nl         = 1'b0;
        ld         = 1'b0;
        zero       = 1'b0;
        we_next    = 1'b0;
        busy_next  = 1'b0;
        waddr_next = vram_waddr;
        wdata_next = vram_wdata;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_PUTC: begin
                            we_next    = 1'b1;
                            waddr_next = cursor;
                            wdata_next = cmd_data[7:0];
                            adv        = 1'b1;
                        end
                        OP_SETPOS: begin
                            if ({1'b0, cmd_data} < CELL_LIM) begin
                                ld         = 1'b1;
                                state_next = ST_SETPOS;
                            end
                        end
                        OP_NEWLINE: nl = 1'b1;
                        default: begin
                            state_next = ST_CLEAR;
                            we_next    = 1'b1;
                            busy_next  = 1'b1;
                            waddr_next = '0;
                            wdata_next = cmd_data[7:0];
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                // vram_waddr doubles as the clear counter.
                if (vram_waddr == LAST_CELL) begin
                    state_next = ST_IDLE;
                    zero       = 1'b1;
                end else begin
                    we_next    = 1'b1;
                    busy_next  = 1'b1;
                    waddr_next = vram_waddr + 1'b1;
                end
            end
            ST_SETPOS: begin
                if (!settling) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            vram_we    <= we_next;
            vram_waddr <= waddr_next;
            vram_wdata <= wdata_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_vram_console.sv
// Directed bench for vram_console: a table of single commands with expected
// write/cursor results, then clear and reset-during-clear sequences.
module tb_vram_console;
    import vram_console_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [10:0] cmd_data = '0;
    logic [10:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [10:0] cursor;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    vram_console dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .cursor     (cursor),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [10:0] data;
        logic        chk_ready;
        logic        exp_we;
        logic [10:0] exp_waddr;
        logic [7:0]  exp_wdata;
        logic [10:0] exp_cursor;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents a command at the falling edge and returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [10:0] data, output logic rdy_first);
        int waits;
        @(negedge clk);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        rdy_first = cmd_ready;
        waits     = 0;
        while (!cmd_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", waits);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic r;
        int   bad, waits, writes;

        vecs[0]  = '{OP_PUTC,    11'h41,   1'b1, 1'b1, 11'd0,    8'h41, 11'd1};
        vecs[1]  = '{OP_PUTC,    11'h42,   1'b1, 1'b1, 11'd1,    8'h42, 11'd2};
        vecs[2]  = '{OP_PUTC,    11'h43,   1'b1, 1'b1, 11'd2,    8'h43, 11'd3};
        vecs[3]  = '{OP_SETPOS,  11'd39,   1'b1, 1'b0, 11'd0,    8'h00, 11'd39};
        vecs[4]  = '{OP_PUTC,    11'h78,   1'b0, 1'b1, 11'd39,   8'h78, 11'd40};
        vecs[5]  = '{OP_NEWLINE, 11'd0,    1'b1, 1'b0, 11'd0,    8'h00, 11'd80};
        vecs[6]  = '{OP_SETPOS,  11'd1199, 1'b1, 1'b0, 11'd0,    8'h00, 11'd1199};
        vecs[7]  = '{OP_PUTC,    11'h7a,   1'b0, 1'b1, 11'd1199, 8'h7a, 11'd0};
        vecs[8]  = '{OP_SETPOS,  11'd1170, 1'b1, 1'b0, 11'd0,    8'h00, 11'd1170};
        vecs[9]  = '{OP_PUTC,    11'h71,   1'b0, 1'b1, 11'd1170, 8'h71, 11'd1171};
        vecs[10] = '{OP_NEWLINE, 11'd0,    1'b1, 1'b0, 11'd0,    8'h00, 11'd0};
        vecs[11] = '{OP_SETPOS,  11'd1200, 1'b1, 1'b0, 11'd0,    8'h00, 11'd0};
        vecs[12] = '{OP_SETPOS,  11'd85,   1'b1, 1'b0, 11'd0,    8'h00, 11'd85};
        vecs[13] = '{OP_NEWLINE, 11'd0,    1'b0, 1'b0, 11'd0,    8'h00, 11'd120};
        vecs[14] = '{OP_SETPOS,  11'd2047, 1'b1, 1'b0, 11'd0,    8'h00, 11'd120};
        vecs[15] = '{OP_SETPOS,  11'd79,   1'b1, 1'b0, 11'd0,    8'h00, 11'd79};
        vecs[16] = '{OP_PUTC,    11'h21,   1'b0, 1'b1, 11'd79,   8'h21, 11'd80};
        vecs[17] = '{OP_NEWLINE, 11'd0,    1'b1, 1'b0, 11'd0,    8'h00, 11'd120};

        // Reset: ready low while reset is held, everything zero afterwards.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", int'(cmd_ready), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_we", int'(vram_we), 0);
        check("rst_waddr", int'(vram_waddr), 0);
        check("rst_wdata", int'(vram_wdata), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].op, vecs[i].data, r);
            if (vecs[i].chk_ready) check($sformatf("v%0d_ready", i), int'(r), 1);
            check($sformatf("v%0d_we", i), int'(vram_we), int'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_waddr", i), int'(vram_waddr), int'(vecs[i].exp_waddr));
                check($sformatf("v%0d_wdata", i), int'(vram_wdata), int'(vecs[i].exp_wdata));
            end
            check($sformatf("v%0d_cursor", i), int'(cursor), int'(vecs[i].exp_cursor));
        end

        // CLEAR with a PUTC held behind it.
        send(OP_CLEAR, 11'h020, r);
        check("clr_ready", int'(r), 1);
        cmd_op    = OP_PUTC;
        cmd_data  = 11'h050;
        cmd_valid = 1'b1;
        bad    = 0;
        writes = 0;
        for (int i = 0; i < 1200; i++) begin
            if (vram_we) writes++;
            if (!(vram_we === 1'b1 && vram_waddr === 11'(i) && vram_wdata === 8'h20 &&
                  busy === 1'b1 && cmd_ready === 1'b0)) bad++;
            @(posedge clk);
            #1;
        end
        check("clr_writes", writes, 1200);
        check("clr_bad_cycles", bad, 0);
        check("clr_end_we", int'(vram_we), 0);
        check("clr_end_busy", int'(busy), 0);
        check("clr_end_cursor", int'(cursor), 0);
        check("clr_end_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("held_putc_we", int'(vram_we), 1);
        check("held_putc_waddr", int'(vram_waddr), 0);
        check("held_putc_wdata", int'(vram_wdata), 8'h50);
        check("held_putc_cursor", int'(cursor), 1);
        @(posedge clk);
        #1;
        check("held_putc_once", int'(vram_we), 0);

        // Reset in the middle of a clear.
        send(OP_CLEAR, 11'h02E, r);
        waits = 0;
        while (!(vram_we === 1'b1 && vram_waddr === 11'd499) && waits < 2000) begin
            @(posedge clk);
            #1;
            waits++;
        end
        check("midclr_reach_499", int'(vram_we === 1'b1 && vram_waddr === 11'd499), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midclr_ready_in_reset", int'(cmd_ready), 0);
        check("midclr_we", int'(vram_we), 0);
        check("midclr_cursor", int'(cursor), 0);
        check("midclr_busy", int'(busy), 0);
        reset  = 1'b0;
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (vram_we !== 1'b0) writes++;
        end
        check("midclr_no_more_writes", writes, 0);
        check("midclr_ready_after", int'(cmd_ready), 1);
        send(OP_PUTC, 11'h04B, r);
        check("post_rst_putc_waddr", int'(vram_waddr), 0);
        check("post_rst_putc_we", int'(vram_we), 1);
        check("post_rst_putc_cursor", int'(cursor), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
